// File: rtl/uart_recv.sv
// UART 8N1 receiver: synchronises uart_rxd, finds the start edge, samples each bit mid-way, strobes out one byte.
// Latency: uart_done rises 3 + 9*BPS_CNT + BPS_CNT/2 + 1 clocks after the uart_rxd falling edge.
// No backpressure: uart_done is a one-cycle strobe, and uart_data holds its value until the next strobe.
//
// Ports:
//   sys_clk        system clock
//   sys_rst_n      synchronous active-low reset
//   uart_rxd       serial input, idle high, asynchronous to sys_clk
//   uart_done      one-cycle pulse, uart_data holds a new byte
//   uart_data      last received byte
//   uart_rx_busy   high while a frame is being received
//   uart_frame_err one-cycle pulse on a bad stop bit (present only with UART_RX_FRAME_ERR_EN)
// Optional feature macro: UART_RX_FRAME_ERR_EN (stop-bit checking and the uart_frame_err port).

module uart_recv #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int UART_BPS = 115200
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       uart_rxd,
    output logic       uart_done,
    output logic [7:0] uart_data,
    output logic       uart_rx_busy
`ifdef UART_RX_FRAME_ERR_EN
    ,
    output logic       uart_frame_err
`endif
);

    localparam logic [15:0] BPS_CNT   = 16'(CLK_FREQ / UART_BPS);
    localparam logic [15:0] SAMPLE_PT = BPS_CNT / 16'd2;

    logic        r_rxd_d0;
    logic        r_rxd_d1;
    logic        r_rxd_d2;
    logic        r_rx_flag;
    logic [15:0] r_clk_cnt;
    logic [3:0]  r_rx_cnt;
    logic [7:0]  r_rx_data;
    logic        r_uart_done;
    logic [7:0]  r_uart_data;
`ifdef UART_RX_FRAME_ERR_EN
    logic        r_frame_err;
`endif

    logic        w_start_flag;
    logic        w_sample;
    logic [2:0]  w_bit_idx;

    // Falling edge on the synchronised line while idle. Edges during a frame are ignored.
    assign w_start_flag = r_rxd_d2 & ~r_rxd_d1 & ~r_rx_flag;
    assign w_sample     = (r_clk_cnt == SAMPLE_PT);
    // Data bits arrive with rx_cnt 1..8. The low 3 bits minus one map them onto 0..7 (8 wraps to 7).
    assign w_bit_idx    = r_rx_cnt[2:0] - 3'd1;

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_rxd_d0    <= 1'b1;
            r_rxd_d1    <= 1'b1;
            r_rxd_d2    <= 1'b1;
            r_rx_flag   <= 1'b0;
            r_clk_cnt   <= 16'd0;
            r_rx_cnt    <= 4'd0;
            r_rx_data   <= 8'h00;
            r_uart_done <= 1'b0;
            r_uart_data <= 8'h00;
`ifdef UART_RX_FRAME_ERR_EN
            r_frame_err <= 1'b0;
`endif
        end else begin
            r_rxd_d0    <= uart_rxd;
            r_rxd_d1    <= r_rxd_d0;
            r_rxd_d2    <= r_rxd_d1;
            r_uart_done <= 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
            r_frame_err <= 1'b0;
`endif
            if (w_start_flag) begin
                r_rx_flag <= 1'b1;
                r_clk_cnt <= 16'd0;
                r_rx_cnt  <= 4'd0;
            end else if (r_rx_flag) begin
                if (w_sample && (r_rx_cnt == 4'd0) && r_rxd_d1) begin
                    // Start bit went high again by mid-bit: a glitch, so drop back to idle quietly.
                    r_rx_flag <= 1'b0;
                    r_clk_cnt <= 16'd0;
                    r_rx_cnt  <= 4'd0;
                end else if (w_sample && (r_rx_cnt == 4'd9)) begin
                    // End the frame at mid-stop-bit so the next start edge can be seen even with no idle gap.
                    r_rx_flag <= 1'b0;
                    r_clk_cnt <= 16'd0;
                    r_rx_cnt  <= 4'd0;
`ifdef UART_RX_FRAME_ERR_EN
                    if (r_rxd_d1) begin
                        r_uart_done <= 1'b1;
                        r_uart_data <= r_rx_data;
                    end else begin
                        r_frame_err <= 1'b1;
                    end
`else
                    r_uart_done <= 1'b1;
                    r_uart_data <= r_rx_data;
`endif
                end else begin
                    if (w_sample && (r_rx_cnt != 4'd0)) begin
                        r_rx_data[w_bit_idx] <= r_rxd_d1;
                    end
                    if (r_clk_cnt == BPS_CNT - 16'd1) begin
                        r_clk_cnt <= 16'd0;
                        r_rx_cnt  <= r_rx_cnt + 4'd1;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 16'd1;
                    end
                end
            end
        end
    end

    assign uart_done    = r_uart_done;
    assign uart_data    = r_uart_data;
    assign uart_rx_busy = r_rx_flag;
`ifdef UART_RX_FRAME_ERR_EN
    assign uart_frame_err = r_frame_err;
`endif

endmodule

// File: tb/tb_uart_recv.sv
// Directed bench for uart_recv at 50 MHz / 115200 baud (434 clocks per bit).
// Latency: the expected done latency is 4127 clocks from the falling start edge driven on uart_rxd.
// Stimulus is driven on negedge; a monitor samples outputs 5 ns after each posedge.

module tb_uart_recv;

    localparam int BIT = 434;
    localparam int LAT = 3 + 9 * BIT + BIT / 2 + 1;  // 4127

    logic       sys_clk   = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       uart_rxd  = 1'b1;
    logic       uart_done;
    logic [7:0] uart_data;
    logic       uart_rx_busy;
`ifdef UART_RX_FRAME_ERR_EN
    logic       uart_frame_err;
`endif

    uart_recv #(.CLK_FREQ(50_000_000), .UART_BPS(115200)) dut (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .uart_rxd     (uart_rxd),
        .uart_done    (uart_done),
        .uart_data    (uart_data),
        .uart_rx_busy (uart_rx_busy)
`ifdef UART_RX_FRAME_ERR_EN
        ,
        .uart_frame_err (uart_frame_err)
`endif
    );

    always #10 sys_clk = ~sys_clk;

    int          tests = 0;
    int          fails = 0;
    int unsigned cyc = 0;
    int unsigned done_hi = 0;
    int unsigned err_hi = 0;
    int unsigned busy_cycles = 0;
    int unsigned busy_rise = 0;
    int unsigned busy_fall = 0;
    int unsigned t_start = 0;
    logic        prev_done = 1'b0;
    logic        prev_busy = 1'b0;
    logic [7:0]  done_q[$];
    int unsigned done_cyc_q[$];

    // Monitor: cyc equals the number of posedges seen so far.
    always @(posedge sys_clk) begin
        #5;
        cyc++;
        if (uart_done === 1'b1) begin
            done_hi++;
            if (!prev_done) begin
                done_q.push_back(uart_data);
                done_cyc_q.push_back(cyc);
            end
        end
        prev_done = (uart_done === 1'b1);
        if (uart_rx_busy === 1'b1) begin
            busy_cycles++;
            if (!prev_busy) busy_rise = cyc;
        end else if (prev_busy) begin
            busy_fall = cyc;
        end
        prev_busy = (uart_rx_busy === 1'b1);
`ifdef UART_RX_FRAME_ERR_EN
        if (uart_frame_err === 1'b1) err_hi++;
`endif
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    // Caller must be at a negedge. Drives start, 8 data bits LSB first, then the stop bit.
    task automatic send_frame(input logic [7:0] b, input logic stop);
        uart_rxd = 1'b0;
        t_start  = cyc;
        wait_clks(BIT);
        for (int i = 0; i < 8; i++) begin
            uart_rxd = b[i];
            wait_clks(BIT);
        end
        uart_rxd = stop;
        wait_clks(BIT);
        uart_rxd = 1'b1;
    endtask

    initial begin
        int unsigned t_a;
        int unsigned b0;
        int          n;
        logic [7:0]  v;

        // Reset state
        sys_rst_n = 1'b0;
        uart_rxd  = 1'b1;
        wait_clks(3);
        chk("rst_busy", {31'd0, uart_rx_busy}, 32'd0);
        chk("rst_done", {31'd0, uart_done}, 32'd0);
        chk("rst_data", {24'd0, uart_data}, 32'h00);
        sys_rst_n = 1'b1;

        // Idle line held high: nothing happens
        wait_clks(3000);
        chk("idle_done_cnt", done_q.size(), 0);
        chk("idle_busy_cycles", busy_cycles, 0);

        // Single frame 0x55
        send_frame(8'h55, 1'b1);
        wait_clks(300);
        chk("f1_done_cnt", done_q.size(), 1);
        chk("f1_data_at_done", {24'd0, done_q[0]}, 32'h55);
        chk("f1_done_width", done_hi, 1);
        chk("f1_latency", done_cyc_q[0] - t_start, LAT);
        chk("f1_busy_rise", busy_rise - t_start, 3);
        chk("f1_busy_fall_at_stop", busy_fall, done_cyc_q[0]);
        chk("f1_data_hold", {24'd0, uart_data}, 32'h55);

        // Back-to-back 0xA5, 0x3C with no idle gap
        send_frame(8'hA5, 1'b1);
        t_a = t_start;
        send_frame(8'h3C, 1'b1);
        wait_clks(300);
        chk("b2b_done_cnt", done_q.size(), 3);
        chk("b2b_first", {24'd0, done_q[1]}, 32'hA5);
        chk("b2b_second", {24'd0, done_q[2]}, 32'h3C);
        chk("b2b_first_lat", done_cyc_q[1] - t_a, LAT);
        chk("b2b_spacing", done_cyc_q[2] - done_cyc_q[1], 10 * BIT);
        chk("b2b_done_width", done_hi, 3);
        chk("b2b_data_hold", {24'd0, uart_data}, 32'h3C);

        // 100-clock low glitch on idle line
        b0 = busy_cycles;
        uart_rxd = 1'b0;
        wait_clks(100);
        uart_rxd = 1'b1;
        wait_clks(1000);
        chk("glitch_busy_cycles", busy_cycles - b0, 218);
        chk("glitch_busy_low", {31'd0, uart_rx_busy}, 32'd0);
        chk("glitch_no_done", done_q.size(), 3);
        chk("glitch_data", {24'd0, uart_data}, 32'h3C);

        // Frame 0x81 with a bad stop bit
        send_frame(8'h81, 1'b0);
        wait_clks(300);
`ifdef UART_RX_FRAME_ERR_EN
        chk("ferr_pulse", err_hi, 1);
        chk("ferr_no_done", done_q.size(), 3);
        chk("ferr_data_held", {24'd0, uart_data}, 32'h3C);
`else
        chk("nostop_done_cnt", done_q.size(), 4);
        chk("nostop_data", {24'd0, done_q[3]}, 32'h81);
        chk("nostop_data_hold", {24'd0, uart_data}, 32'h81);
`endif

        // Reset for 2 clocks in the middle of data bit 4 of 0x55 (bit 4 = 1, line high)
        v = 8'h55;
        uart_rxd = 1'b0;
        wait_clks(BIT);
        for (int i = 0; i < 4; i++) begin
            uart_rxd = v[i];
            wait_clks(BIT);
        end
        uart_rxd = v[4];
        wait_clks(200);
        chk("mid_busy_before_rst", {31'd0, uart_rx_busy}, 32'd1);
        sys_rst_n = 1'b0;
        wait_clks(2);
        chk("mid_rst_busy", {31'd0, uart_rx_busy}, 32'd0);
        chk("mid_rst_done", {31'd0, uart_done}, 32'd0);
        chk("mid_rst_data", {24'd0, uart_data}, 32'h00);
        sys_rst_n = 1'b1;
        uart_rxd  = 1'b1;
        n = done_q.size();
        wait_clks(2000);
        chk("post_rst_no_done", done_q.size(), n);
        chk("post_rst_busy", {31'd0, uart_rx_busy}, 32'd0);
        send_frame(8'h3C, 1'b1);
        wait_clks(300);
        chk("post_rst_done_cnt", done_q.size(), n + 1);
        chk("post_rst_data", {24'd0, uart_data}, 32'h3C);
        chk("post_rst_latency", done_cyc_q[n] - t_start, LAT);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
